st_unit: RTL and testbench

//   Store path of the data-memory interface; the write-direction counterpart of the load converter.

---
 rtl/rv32i_pkg.sv | 21 ++
 rtl/st_formatter.sv | 40 ++++
 rtl/st_unit.sv | 128 ++++++++++++
 tb/tb_st_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the data-memory store path.
// Store funct3 encodings, strobe width and the store-buffer entry layout.
package rv32i_pkg;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   localparam int WSTRB_W = 4;

   typedef struct packed {
      logic [29:0]         waddr;
      logic [31:0]         wdata;
      logic [WSTRB_W-1:0]  wstrb;
   } sb_entry_t;

   function automatic logic [31:0] word_addr(input logic [29:0] w);
      return {w, 2'b00};
   endfunction

endpackage

// File: rtl/st_formatter.sv
// Store formatter: replicates rs2 data onto byte lanes and builds strobes.
// Flags misaligned halfword/word stores and unknown funct3 encodings.
module st_formatter
   import rv32i_pkg::*;
(
   input  logic [1:0]          off,
   input  logic [2:0]          funct3,
   input  logic [31:0]         data,
   output logic [31:0]         wdata,
   output logic [WSTRB_W-1:0]  wstrb,
   output logic                err
);

   // Lane replication and strobe generation by access size
   always_comb begin
      wdata = '0;
      wstrb = '0;
      err   = 1'b0;
      case (funct3)
         F3_SB: begin
            wdata = {4{data[7:0]}};
            wstrb = 4'b0001 << off;
         end
         F3_SH: begin
            wdata = {2{data[15:0]}};
            wstrb = off[1] ? 4'b1100 : 4'b0011;
            err   = off[0];
         end
         F3_SW: begin
            wdata = data;
            wstrb = 4'b1111;
            err   = |off;
         end
         default: begin
            err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/st_unit.sv
// Store path: formats MEM-stage stores and queues them in an in-order
// store buffer that drains to data memory over a valid/ack handshake.
module st_unit
   import rv32i_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [31:0]              st_addr,
   input  logic [31:0]              st_data,
   input  logic [2:0]               funct3,
   output logic                     st_err,
   output logic                     mem_req,
   input  logic                     mem_ack,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [WSTRB_W-1:0]       mem_wstrb,
   output logic                     sb_empty,
   output logic [$clog2(DEPTH):0]   sb_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   sb_entry_t           buf_q [DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic                err_q;

   logic [31:0]         f_wdata;
   logic [WSTRB_W-1:0]  f_wstrb;
   logic                f_err;

   logic                full;
   logic                empty;
   logic                accept;
   logic                push;
   logic                pop;
   sb_entry_t           head;
   sb_entry_t           new_ent;

   st_formatter u_fmt (
      .off    (st_addr[1:0]),
      .funct3 (funct3),
      .data   (st_data),
      .wdata  (f_wdata),
      .wstrb  (f_wstrb),
      .err    (f_err)
   );

   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);
   assign accept = st_valid && !full;
   assign push   = accept && !f_err;
   assign pop    = !empty && mem_ack;

   assign new_ent.waddr = st_addr[31:2];
   assign new_ent.wdata = f_wdata;
   assign new_ent.wstrb = f_wstrb;

   assign head = buf_q[rd_ptr];

   // Entry storage: write the formatted store at the tail
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= '0;
         end
      end else if (push) begin
         buf_q[wr_ptr] <= new_ent;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // One-cycle error pulse for a rejected but accepted store
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= accept && f_err;
      end
   end

   // Head presentation; idle bus is driven to zero
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      if (!empty) begin
         mem_addr  = word_addr(head.waddr);
         mem_wdata = head.wdata;
         mem_wstrb = head.wstrb;
      end
   end

   assign st_ready = !full;
   assign st_err   = err_q;
   assign mem_req  = !empty;
   assign sb_empty = empty;
   assign sb_count = count;

endmodule

// File: tb/tb_st_unit.sv
// Bench for st_unit: queue-based reference model checked every cycle,
// plus directed store sequences with literal expectations.
module tb_st_unit;

   localparam int DEPTH = 4;

   logic         clk;
   logic         rst_n;
   logic         st_valid;
   logic         st_ready;
   logic [31:0]  st_addr;
   logic [31:0]  st_data;
   logic [2:0]   funct3;
   logic         st_err;
   logic         mem_req;
   logic         mem_ack;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic [3:0]   mem_wstrb;
   logic         sb_empty;
   logic [2:0]   sb_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } ent_t;

   ent_t mq[$];
   logic m_err;

   st_unit #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .funct3    (funct3),
      .st_err    (st_err),
      .mem_req   (mem_req),
      .mem_ack   (mem_ack),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .sb_empty  (sb_empty),
      .sb_count  (sb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // Size-based formatting: lane i carries byte (i mod size) of rs2
   function automatic void fmt(input logic [31:0] addr, input logic [31:0] data,
                               input logic [2:0] f3, output ent_t e,
                               output logic bad);
      int sz;
      int off;
      off = int'(addr[1:0]);
      sz  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
      bad = (sz == 0) || ((off % sz) != 0);
      e.a = {addr[31:2], 2'b00};
      e.d = '0;
      e.s = '0;
      if (!bad) begin
         for (int i = 0; i < 4; i++) begin
            e.d[8*i +: 8] = data[8*(i % sz) +: 8];
            e.s[i] = (i >= off) && (i < off + sz);
         end
      end
   endfunction

   // Reference model: FIFO of formatted stores
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_err = 1'b0;
      end else begin
         ent_t e;
         logic bad;
         logic rdy;
         rdy = (mq.size() < DEPTH);
         fmt(st_addr, st_data, funct3, e, bad);
         if (mq.size() > 0 && mem_ack) void'(mq.pop_front());
         m_err = st_valid && rdy && bad;
         if (st_valid && rdy && !bad) mq.push_back(e);
      end
   end

   // Cycle-by-cycle compare against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("st_ready", 32'(st_ready), 32'(mq.size() < DEPTH));
         chk("sb_count", 32'(sb_count), 32'(mq.size()));
         chk("sb_empty", 32'(sb_empty), 32'(mq.size() == 0));
         chk("mem_req", 32'(mem_req), 32'(mq.size() != 0));
         chk("st_err", 32'(st_err), 32'(m_err));
         if (mq.size() != 0) begin
            chk("mem_addr", mem_addr, mq[0].a);
            chk("mem_wdata", mem_wdata, mq[0].d);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(mq[0].s));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic v, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f,
                        input logic ack);
      st_valid = v;
      st_addr  = a;
      st_data  = d;
      funct3   = f;
      mem_ack  = ack;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
      repeat (3) cyc();
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst sb_empty", 32'(sb_empty), 32'd1);
      chk("rst sb_count", 32'(sb_count), 32'd0);
      chk("rst st_err", 32'(st_err), 32'd0);
      chk("rst mem_addr", mem_addr, 32'd0);
      chk("rst mem_wdata", mem_wdata, 32'd0);
      chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
      rst_n = 1'b1;
      cyc();

      // SB at offset 3
      drive(1'b1, 32'h1003, 32'hAABBCCDD, 3'b000, 1'b0);
      cyc();
      drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
      chk("sb mem_req", 32'(mem_req), 32'd1);
      chk("sb mem_addr", mem_addr, 32'h1000);
      chk("sb wdata", mem_wdata, 32'hDDDDDDDD);
      chk("sb wstrb", 32'(mem_wstrb), 32'h8);
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      chk("sb drained", 32'(sb_count), 32'd0);

      // SH upper half
      drive(1'b1, 32'h2002, 32'h1234BEEF, 3'b001, 1'b0);
      cyc();
      drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
      chk("sh wdata", mem_wdata, 32'hBEEFBEEF);
      chk("sh wstrb", 32'(mem_wstrb), 32'hC);
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;

      // Misaligned SW and illegal funct3
      drive(1'b1, 32'h2002, 32'h55667788, 3'b010, 1'b0);
      cyc();
      drive(1'b1, 32'h3000, 32'h1, 3'b011, 1'b0);
      chk("sw misal err", 32'(st_err), 32'd1);
      chk("sw misal count", 32'(sb_count), 32'd0);
      cyc();
      drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
      chk("illegal f3 err", 32'(st_err), 32'd1);
      cyc();
      chk("err one pulse", 32'(st_err), 32'd0);

      // Fill the buffer with ack held low
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h100 + 32'(4*i), 32'(i + 1), 3'b010, 1'b0);
         cyc();
      end
      chk("full ready", 32'(st_ready), 32'd0);
      chk("full count", 32'(sb_count), 32'd4);
      drive(1'b1, 32'h200, 32'hDEAD, 3'b010, 1'b0);
      cyc();
      chk("5th ignored", 32'(sb_count), 32'd4);
      chk("hold addr", mem_addr, 32'h100);
      chk("hold data", mem_wdata, 32'h1);

      // Full plus pop with a store offered: pop only
      drive(1'b1, 32'h200, 32'hDEAD, 3'b010, 1'b1);
      chk("ready before", 32'(st_ready), 32'd0);
      cyc();
      drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
      chk("pop only cnt", 32'(sb_count), 32'd3);
      chk("ready after", 32'(st_ready), 32'd1);
      for (int i = 1; i < 4; i++) begin
         chk("order addr", mem_addr, 32'h100 + 32'(4*i));
         chk("order data", mem_wdata, 32'(i + 1));
         cyc();
      end
      chk("drain empty", 32'(sb_empty), 32'd1);

      // Push and pop every cycle
      drive(1'b1, 32'h3000, 32'h0, 3'b010, 1'b0);
      cyc();
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 32'h3000 + 32'(4*i), 32'(i), 3'b010, 1'b1);
         cyc();
         chk("stream count", 32'(sb_count), 32'd1);
         chk("stream addr", mem_addr, 32'h3000 + 32'(4*i));
      end
      drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
      cyc();
      mem_ack = 1'b0;
      chk("stream empty", 32'(sb_empty), 32'd1);

      // Reset with three pending stores
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h4000 + 32'(4*i), 32'(i), 3'b000, 1'b0);
         cyc();
      end
      drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
      chk("pre-rst count", 32'(sb_count), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("async mem_req", 32'(mem_req), 32'd0);
      chk("async sb_empty", 32'(sb_empty), 32'd1);
      chk("async mem_addr", mem_addr, 32'd0);
      cyc();
      mem_ack = 1'b0;
      rst_n = 1'b1;
      repeat (3) cyc();
      chk("no replay", 32'(mem_req), 32'd0);
      chk("no replay cnt", 32'(sb_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
